// File: rtl/fpu_norm_pkg.sv
// Shared definitions for the post-adder normalizer: FSM states, default widths
// and the saturating exponent limit.
package fpu_norm_pkg;

  localparam int unsigned DefW  = 24;
  localparam int unsigned DefEW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StShiftL,
    StDone
  } state_e;

  // All-ones value of an ew-bit exponent; callers truncate to their own width.
  function automatic logic [31:0] exp_all_ones(input int unsigned ew);
    return (32'h1 << ew) - 32'h1;
  endfunction

endpackage

// File: rtl/add_sub_normalizer.sv
// Sequential normalizer for a (W+1)-bit add/sub result: one right shift on carry,
// otherwise iterative one-bit-per-cycle left shifts until the hidden bit is set.
module add_sub_normalizer
  import fpu_norm_pkg::*;
#(
  parameter int unsigned W  = DefW,
  parameter int unsigned EW = DefEW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W:0]    Data_S,
  input  logic [EW-1:0] Exp_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  Data_N,
  output logic [EW-1:0] Exp_out,
  output logic          lost_bit,
  output logic          zero_flag,
  output logic          ovf_flag,
  output logic          unf_flag
);

  localparam logic [EW-1:0] ExpMax = EW'(exp_all_ones(EW));
  localparam logic [EW-1:0] ExpOne = EW'(1);

  state_e        state_q, state_d;
  logic [W:0]    data_q, data_d;
  logic [EW-1:0] exp_q, exp_d;
  logic          lost_q, lost_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      exp_q   <= '0;
      lost_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      exp_q   <= exp_d;
      lost_q  <= lost_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    exp_d   = exp_q;
    lost_d  = lost_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = Data_S;
          exp_d   = Exp_in;
          lost_d  = 1'b0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = StEval;
        end
      end
      StEval: begin
        if (data_q[W]) begin
          data_d  = data_q >> 1;
          lost_d  = data_q[0];
          // Increment saturates at all-ones; landing there is an overflow.
          exp_d   = (exp_q == ExpMax) ? ExpMax : exp_q + ExpOne;
          ovf_d   = (exp_d == ExpMax);
          state_d = StDone;
        end else if (data_q == '0) begin
          exp_d   = '0;
          zero_d  = 1'b1;
          state_d = StDone;
        end else if (data_q[W-1]) begin
          state_d = StDone;
        end else if (exp_q == '0) begin
          unf_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StShiftL;
        end
      end
      StShiftL: begin
        // Entered only with a nonzero exponent, so the decrement cannot wrap.
        data_d = data_q << 1;
        exp_d  = exp_q - ExpOne;
        if (data_d[W-1]) begin
          state_d = StDone;
        end else if (exp_d == '0) begin
          unf_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle) & ~rst;
  assign out_valid = (state_q == StDone);
  assign Data_N    = data_q[W-1:0];
  assign Exp_out   = exp_q;
  assign lost_bit  = lost_q;
  assign zero_flag = zero_q;
  assign ovf_flag  = ovf_q;
  assign unf_flag  = unf_q;

endmodule

// File: tb/tb_add_sub_normalizer.sv
// Directed bench for add_sub_normalizer with W=24, EW=8.
module tb_add_sub_normalizer;

  localparam int unsigned W  = 24;
  localparam int unsigned EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W:0]    data_s;
  logic [EW-1:0] exp_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  data_n;
  logic [EW-1:0] exp_out;
  logic          lost_bit, zero_flag, ovf_flag, unf_flag;
  logic [3:0]    flags;

  int checks = 0;
  int failures = 0;

  assign flags = {lost_bit, zero_flag, ovf_flag, unf_flag};

  always #5 clk = ~clk;

  add_sub_normalizer #(.W(W), .EW(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Data_S    (data_s),
    .Exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Data_N    (data_n),
    .Exp_out   (exp_out),
    .lost_bit  (lost_bit),
    .zero_flag (zero_flag),
    .ovf_flag  (ovf_flag),
    .unf_flag  (unf_flag)
  );

  // Issue one operand at posedge+1 and count edges after acceptance until out_valid.
  task automatic run_op(input logic [W:0] d, input logic [EW-1:0] e, output int lat,
                        output logic [W-1:0] dn, output logic [EW-1:0] eo,
                        output logic [3:0] fl);
    data_s   = d;
    exp_in   = e;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    dn = data_n;
    eo = exp_out;
    fl = flags;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_s = '0; exp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, data_n, exp_out, flags} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b dn=%h e=%0d fl=%b required all 0",
               in_ready, out_valid, data_n, exp_out, flags);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vector(input string name, input logic [W:0] d, input logic [EW-1:0] e,
                             input int exp_lat, input logic [W-1:0] exp_dn,
                             input logic [EW-1:0] exp_eo, input logic [3:0] exp_fl);
    int lat;
    logic [W-1:0] dn;
    logic [EW-1:0] eo;
    logic [3:0] fl;
    run_op(d, e, lat, dn, eo, fl);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if ({dn, eo, fl} !== {exp_dn, exp_eo, exp_fl}) begin
      failures++;
      $display("FAIL %s_result: got dn=%h e=%0d fl=%b required dn=%h e=%0d fl=%b",
               name, dn, eo, fl, exp_dn, exp_eo, exp_fl);
    end
    release_out();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL %s_handoff: got rdy=%b vld=%b required rdy=1 vld=0",
               name, in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] dn;
    logic [EW-1:0] eo;
    logic [3:0] fl;
    run_op(25'h0800000, 8'd10, lat, dn, eo, fl);
    // Hold back-pressure while a second operand waits on in_valid.
    data_s   = 25'h1800001;
    exp_in   = 8'd100;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, data_n, exp_out, flags} !==
          {1'b1, 1'b0, 24'h800000, 8'd10, 4'b0000}) begin
        failures++;
        $display("FAIL backpressure_hold%0d: got vld=%b rdy=%b dn=%h e=%0d fl=%b", i,
                 out_valid, in_ready, data_n, exp_out, flags);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_idle: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_accept: got rdy=%b vld=%b required rdy=0 vld=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, data_n, exp_out, flags} !== {1'b1, 24'hC00000, 8'd101, 4'b1000}) begin
      failures++;
      $display("FAIL b2b_second: got vld=%b dn=%h e=%0d fl=%b required vld=1 dn=c00000 e=101 fl=1000",
               out_valid, data_n, exp_out, flags);
    end
    release_out();
  endtask

  task automatic test_reset_mid_op();
    data_s   = 25'h0000001;
    exp_in   = 8'd100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, data_n, exp_out, flags} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got rdy=%b vld=%b dn=%h e=%0d fl=%b required all 0",
               in_ready, out_valid, data_n, exp_out, flags);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL midreset_idle: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vector("carry",      25'h1800001, 8'd100, 1,  24'hC00000, 8'd101, 4'b1000);
    test_vector("normalized", 25'h0800000, 8'd10,  1,  24'h800000, 8'd10,  4'b0000);
    test_vector("max_shift",  25'h0000001, 8'd100, 24, 24'h800000, 8'd77,  4'b0000);
    test_vector("underflow",  25'h0000100, 8'd3,   4,  24'h000800, 8'd0,   4'b0001);
    test_vector("overflow",   25'h1000000, 8'd254, 1,  24'h800000, 8'd255, 4'b0010);
    test_vector("saturate",   25'h1000001, 8'd255, 1,  24'h800000, 8'd255, 4'b1010);
    test_vector("zero",       25'h0000000, 8'd50,  1,  24'h000000, 8'd0,   4'b0100);
    test_vector("exp0_unf",   25'h0000100, 8'd0,   1,  24'h000100, 8'd0,   4'b0001);
    test_vector("exact_norm", 25'h0400000, 8'd1,   2,  24'h800000, 8'd0,   4'b0000);
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
